// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer with flush.
// Optional zero-latency empty-queue bypass enabled by defining IQ_BYPASS_EN.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_misalign,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] mis_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty, push, pop, byp;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL);
  assign count    = count_q;

`ifdef IQ_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word that decode takes immediately is never written.
  assign push = in_valid & in_ready & ~flush & ~(byp & out_ready);
  assign pop  = ~empty & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload is never reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= in_inst;
      mis_q[wr_ptr_q]  <= (in_pc[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_valid    = ~empty;
    out_pc       = empty ? 32'h0 : pc_q[rd_ptr_q];
    out_inst     = empty ? 32'h0 : inst_q[rd_ptr_q];
    out_misalign = ~empty & mis_q[rd_ptr_q];
`ifdef IQ_BYPASS_EN
    if (byp) begin
      out_valid    = 1'b1;
      out_pc       = in_pc;
      out_inst     = in_inst;
      out_misalign = (in_pc[1:0] != 2'b00);
    end
`endif
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, streaming wrap, flush,
// misalign and empty-queue latency (both IQ_BYPASS_EN builds).
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_misalign(out_misalign), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = 32'h8C01_0000 | pc;
    out_ready = rdy;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_misalign", 32'(out_misalign), 32'd0);
    cyc();
    rst = 1'b0;

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      #1;
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h10, 1'b0);
    cyc();
    chk("fifth_ignored", 32'(count), 32'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_inst", out_inst, 32'h8C01_0000 | 32'(4 * i));
      chk("drain_count", 32'(count), 32'(4 - i));
      cyc();
      if (i == 0) chk("unfull_in_ready", 32'(in_ready), 32'd1);
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_inst", out_inst, 32'h0);

    // Asynchronous reset with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h80 + 4 * i), 1'b0);
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_inst", out_inst, 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    rst = 1'b0;

    // Streaming through pointer wrap
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'(32'h200 + 4 * k), 1'b1);
      #1;
`ifdef IQ_BYPASS_EN
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", out_pc, 32'(32'h200 + 4 * k));
      chk("stream_count", 32'(count), 32'd0);
`else
      if (k > 0) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_pc", out_pc, 32'(32'h200 + 4 * (k - 1)));
        chk("stream_count", 32'(count), 32'd1);
      end
`endif
      cyc();
    end
    drive(1'b0, 32'h0, 1'b1);
`ifndef IQ_BYPASS_EN
    #1;
    chk("stream_tail_pc", out_pc, 32'h24C);
`endif
    cyc();
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with simultaneous push and pop at count=2
    drive(1'b1, 32'h30, 1'b0);
    cyc();
    drive(1'b1, 32'h34, 1'b0);
    cyc();
    chk("preflush_count", 32'(count), 32'd2);
    drive(1'b1, 32'h40, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_cycle_pc", out_pc, 32'h30);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_valid", 32'(out_valid), 32'd0);
    chk("postflush_inst", out_inst, 32'h0);
    chk("postflush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("flush_push_gone", 32'(out_valid), 32'd0);

    // Misaligned PC is queued and flagged at the head
    drive(1'b1, 32'h6, 1'b0);
    cyc();
    drive(1'b1, 32'h8, 1'b0);
    #1;
    chk("mis_head_pc", out_pc, 32'h6);
    chk("mis_flag", 32'(out_misalign), 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("mis_count", 32'(count), 32'd2);
    cyc();
    chk("aligned_pc", out_pc, 32'h8);
    chk("aligned_flag", 32'(out_misalign), 32'd0);
    cyc();
    chk("mis_end_count", 32'(count), 32'd0);

    // Empty-queue latency
    drive(1'b1, 32'h100, 1'b1);
    #1;
`ifdef IQ_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_pc", out_pc, 32'h100);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_valid", 32'(out_valid), 32'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    #1;
    chk("nobyp_next_valid", 32'(out_valid), 32'd1);
    chk("nobyp_next_pc", out_pc, 32'h100);
    chk("nobyp_count", 32'(count), 32'd1);
    cyc();
    chk("nobyp_end_count", 32'(count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
